led_btn_debounce: RTL and testbench

//  Conditioning stage directly upstream of the LED inverter core in tt_um_led_jellyant.
//  - Takes a raw, bouncy push-button input (ui_in[0] pad).
//  - Synchronises it to clk and debounces it with a counter-based state machine.
//  - Delivers a clean level, one-cycle rise/fall pulses and a toggle bit.
//  - The downstream inverter stage consumes btn_level (or btn_toggle) in place of the raw pin.

---
 rtl/led_pkg.sv | 16 +
 rtl/led_sync.sv | 25 ++
 rtl/led_btn_debounce.sv | 140 ++++++++++++++
 tb/tb_led_btn_debounce.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED tile input conditioning.
// Holds the debounce FSM state encoding and default timing.
package led_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } dbn_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/led_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs.
// Output is the last stage of the chain; resets to 0.
module led_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the pad value through the flop chain every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/led_btn_debounce.sv
// Push-button conditioner: synchronise, debounce, edge pulses, toggle.
// Feeds a clean level to the LED inverter core in place of the raw pin.
module led_btn_debounce
    import led_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_toggle,
    output logic busy
);

    localparam logic [CNT_W-1:0] DC  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             s;
    dbn_state_t       state;
    dbn_state_t       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_d;
    logic             rise_d;
    logic             fall_d;
    logic             tog_d;
    logic             busy_d;

    led_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (s)
    );

    assign cnt_inc = cnt + ONE;

    // next state, qualification count and registered outputs
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = btn_level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        tog_d   = btn_toggle;
        if (!ena) begin
            state_d = btn_level ? ST_HI : ST_LO;
            cnt_d   = '0;
        end else begin
            unique case (state)
                ST_LO: begin
                    if (s) begin
                        if (DC == ONE) begin
                            state_d = ST_HI;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            rise_d  = 1'b1;
                            tog_d   = ~btn_toggle;
                        end else begin
                            state_d = CHK_HI;
                            cnt_d   = ONE;
                        end
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (cnt_inc == DC) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        tog_d   = ~btn_toggle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        if (DC == ONE) begin
                            state_d = ST_LO;
                            cnt_d   = '0;
                            level_d = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = CHK_LO;
                            cnt_d   = ONE;
                        end
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_d = ST_HI;
                        cnt_d   = '0;
                    end else if (cnt_inc == DC) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end
        busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
    end

    // state, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LO;
            cnt        <= '0;
            btn_level  <= 1'b0;
            btn_rise   <= 1'b0;
            btn_fall   <= 1'b0;
            btn_toggle <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            btn_level  <= level_d;
            btn_rise   <= rise_d;
            btn_fall   <= fall_d;
            btn_toggle <= tog_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_led_btn_debounce.sv
// Bench for led_btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected outputs are queued per driven cycle and compared after the edge.
module tb_led_btn_debounce;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic btn_raw;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic btn_toggle;
    logic busy;
    logic [4:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp_v;

    logic m_sync0, m_sync1, m_level, m_rise, m_fall, m_tog, m_busy;
    int   m_run;

    led_btn_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .btn_toggle (btn_toggle),
        .busy       (busy)
    );

    assign outs = {btn_level, btn_rise, btn_fall, btn_toggle, busy};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync0 = 0; m_sync1 = 0; m_level = 0; m_rise = 0;
        m_fall = 0; m_tog = 0; m_busy = 0; m_run = 0;
    endtask

    // level follows the synchronised input once it has
    // disagreed with the level for DC consecutive edges
    task automatic predict(input logic r, input logic raw, input logic en);
        logic sv;
        if (!r) begin
            model_reset();
        end else begin
            sv = m_sync1;
            m_rise = 0;
            m_fall = 0;
            if (!en || sv == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DC) begin
                    m_run = 0;
                    m_level = sv;
                    if (sv) begin
                        m_rise = 1;
                        m_tog = ~m_tog;
                    end else begin
                        m_fall = 1;
                    end
                end
            end
            m_busy = (m_run != 0);
            m_sync1 = m_sync0;
            m_sync0 = raw;
        end
    endtask

    task automatic step(input logic r, input logic raw, input logic en);
        @(negedge clk);
        rst_n = r;
        btn_raw = raw;
        ena = en;
        predict(r, raw, en);
        exp_q.push_back({m_level, m_rise, m_fall, m_tog, m_busy});
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("sb_outs", 32'(outs), 32'(exp_v));
        end
        if (btn_rise) rise_seen++;
        if (btn_fall) fall_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        model_reset();
        rst_n = 0;
        btn_raw = 1;
        ena = 1;
        // 1. reset with button held high, then release
        repeat (3) step(0, 1, 1);
        chk("rst_outs", 32'(outs), 0);
        for (int i = 0; i <= 6; i++) begin
            step(1, 1, 1);
            chk("t1_rise", 32'(btn_rise), 32'(i == 5));
            chk("t1_level", 32'(btn_level), 32'(i >= 5));
        end
        // reset again with button low
        repeat (2) step(0, 0, 1);
        repeat (3) step(1, 0, 1);
        chk("rst2_outs", 32'(outs), 0);
        // 3. bounce
        r0 = rise_seen;
        repeat (3) begin
            step(1, 1, 1);
            step(1, 1, 1);
            step(1, 0, 1);
        end
        repeat (6) step(1, 0, 1);
        chk("t3_level", 32'(btn_level), 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_rises", 32'(rise_seen), 32'(r0));
        // 2. clean press
        for (int i = 0; i <= 7; i++) begin
            step(1, 1, 1);
            chk("t2_rise", 32'(btn_rise), 32'(i == 5));
            chk("t2_busy", 32'(busy), 32'(i >= 2 && i <= 4));
        end
        chk("t2_toggle", 32'(btn_toggle), 1);
        // 4. release, then second press
        for (int i = 0; i <= 7; i++) begin
            step(1, 0, 1);
            chk("t4_fall", 32'(btn_fall), 32'(i == 5));
            chk("t4_norise", 32'(btn_rise), 0);
        end
        chk("t4_toggle_hold", 32'(btn_toggle), 1);
        repeat (8) step(1, 1, 1);
        chk("t4_toggle_back", 32'(btn_toggle), 0);
        chk("t4_level", 32'(btn_level), 1);
        repeat (8) step(1, 0, 1);
        // 5. ena low during qualification
        repeat (4) step(1, 1, 1);
        chk("t5_busy_pre", 32'(busy), 1);
        repeat (3) begin
            step(1, 1, 0);
            chk("t5_busy_off", 32'(busy), 0);
            chk("t5_norise", 32'(btn_rise), 0);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1, 1, 1);
            chk("t5_rise", 32'(btn_rise), 32'(k == 4));
        end
        repeat (8) step(1, 0, 1);
        // 6. async reset in the middle of CHK_HI
        repeat (4) step(1, 1, 1);
        chk("t6_busy_pre", 32'(busy), 1);
        r0 = rise_seen;
        rst_n = 0;
        #1;
        model_reset();
        chk("t6_async_outs", 32'(outs), 0);
        repeat (2) step(0, 1, 1);
        chk("t6_norise", 32'(rise_seen), 32'(r0));
        for (int i = 0; i <= 7; i++) begin
            step(1, 1, 1);
            chk("t6_rise", 32'(btn_rise), 32'(i == 5));
        end
        repeat (2) @(posedge clk);
        #3;
        chk("sb_drain", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
